// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_bht
//  Description : Direct-mapped table of 2-bit saturating counters indexed by
//                PC. It gives a zero-latency taken/not-taken prediction to IF,
//                is trained by resolved outcomes from EX, and raises a
//                registered mispredict pulse with the redirect direction.
//                It also keeps resolved-branch and misprediction statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_bht #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pred_valid_i,
  input  logic [31:0]      pred_pc_i,
  input  logic [5:0]       pred_op_i,
  output logic             pred_taken_o,
  input  logic             res_valid_i,
  input  logic [31:0]      res_pc_i,
  input  logic [5:0]       res_op_i,
  input  logic             res_taken_i,
  input  logic             res_pred_i,
  output logic             mispredict_o,
  output logic             redirect_taken_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam int         DEPTH    = 1 << IDX_W;
  localparam logic [1:0] CTR_INIT = 2'b01;  // weak not-taken

  // Conditional branch opcodes: beq, bne/bnez, bltz, ble.
  function automatic logic is_branch(input logic [5:0] op);
    return (op == 6'b000100) || (op == 6'b000101) ||
           (op == 6'b000001) || (op == 6'b000110);
  endfunction

  logic [1:0]       tbl_q [DEPTH];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             res_upd;
  logic [1:0]       res_cnt_d;
  logic [1:0]       pred_cnt;
  logic             mispredict_q, mispredict_d;
  logic             redirect_q, redirect_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // Word-aligned PCs: the two low bits and everything above the index are
  // not used for lookup (no tags, aliasing is accepted).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc_i[31:IDX_W+2], pred_pc_i[1:0],
                            res_pc_i[31:IDX_W+2], res_pc_i[1:0]};

  assign pred_idx = pred_pc_i[IDX_W+1:2];
  assign res_idx  = res_pc_i[IDX_W+1:2];
  assign res_upd  = res_valid_i && is_branch(res_op_i);

  // Saturating train value for the resolving entry and next-state of the
  // pulse outputs and statistics.
  always_comb begin
    res_cnt_d     = tbl_q[res_idx];
    mispredict_d  = 1'b0;
    redirect_d    = 1'b0;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (res_taken_i) begin
      if (tbl_q[res_idx] != 2'b11) res_cnt_d = tbl_q[res_idx] + 2'b01;
    end else begin
      if (tbl_q[res_idx] != 2'b00) res_cnt_d = tbl_q[res_idx] - 2'b01;
    end
    if (res_upd) begin
      mispredict_d = (res_taken_i != res_pred_i);
      redirect_d   = res_taken_i;
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (res_taken_i != res_pred_i) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  // Prediction lookup; a same-cycle training of the same entry is forwarded
  // so IF never sees a stale counter.
  always_comb begin
    pred_cnt = tbl_q[pred_idx];
    if (res_upd && (res_idx == pred_idx)) pred_cnt = res_cnt_d;
    pred_taken_o = pred_valid_i && is_branch(pred_op_i) && pred_cnt[1];
  end

  // Counter table: reset to weak not-taken, otherwise train one entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= CTR_INIT;
    end else if (res_upd) begin
      tbl_q[res_idx] <= res_cnt_d;
    end
  end

  // Mispredict/redirect pulses and statistics counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mispredict_q  <= 1'b0;
      redirect_q    <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      mispredict_q  <= mispredict_d;
      redirect_q    <= redirect_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign mispredict_o     = mispredict_q;
  assign redirect_taken_o = redirect_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor_bht
//  Description : Self-checking bench for branch_predictor_bht: directed vector
//                table, randomized traffic against a reference model, and the
//                statistics wrap-around corner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_bht;

  localparam int IDX_W = 6;
  localparam int CNT_W = 16;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLTZ = 6'b000001;
  localparam logic [5:0] OP_BLE  = 6'b000110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic             clk = 1'b0;
  logic             rst;
  logic             pred_valid;
  logic [31:0]      pred_pc;
  logic [5:0]       pred_op;
  logic             pred_taken;
  logic             res_valid;
  logic [31:0]      res_pc;
  logic [5:0]       res_op;
  logic             res_taken;
  logic             res_pred;
  logic             mispredict;
  logic             redirect_taken;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor_bht #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pred_valid_i     (pred_valid),
    .pred_pc_i        (pred_pc),
    .pred_op_i        (pred_op),
    .pred_taken_o     (pred_taken),
    .res_valid_i      (res_valid),
    .res_pc_i         (res_pc),
    .res_op_i         (res_op),
    .res_taken_i      (res_taken),
    .res_pred_i       (res_pred),
    .mispredict_o     (mispredict),
    .redirect_taken_o (redirect_taken),
    .branch_cnt_o     (branch_cnt),
    .mispredict_cnt_o (mispredict_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        pv;
    logic [31:0] ppc;
    logic [5:0]  pop;
    logic        rv;
    logic [31:0] rpc;
    logic [5:0]  rop;
    logic        rt;
    logic        rp;
    logic        e_pred;
    logic        e_mis;
    logic        e_red;
    int          e_bcnt;
    int          e_mcnt;
  } vec_t;

  // ---------------- reference model ----------------
  int m_ctr [DEPTH];
  int m_bcnt, m_mcnt;
  int m_mis, m_red;

  function automatic bit m_is_br(input logic [5:0] op);
    return op inside {OP_BEQ, OP_BNE, OP_BLTZ, OP_BLE};
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'(pc / 4) % DEPTH;
  endfunction

  function automatic int m_trained(input int c, input logic t);
    return t ? ((c + 1 > 3) ? 3 : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
  endfunction

  function automatic logic m_predict();
    int c;
    bit q;
    q = res_valid && m_is_br(res_op);
    c = m_ctr[m_idx(pred_pc)];
    if (q && m_idx(res_pc) == m_idx(pred_pc)) c = m_trained(c, res_taken);
    return pred_valid && m_is_br(pred_op) && (c >= 2);
  endfunction

  task automatic m_edge();
    bit q;
    q = res_valid && m_is_br(res_op);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
      m_bcnt = 0; m_mcnt = 0; m_mis = 0; m_red = 0;
    end else if (q) begin
      m_ctr[m_idx(res_pc)] = m_trained(m_ctr[m_idx(res_pc)], res_taken);
      m_bcnt = (m_bcnt + 1) % (1 << CNT_W);
      m_mis  = (res_taken != res_pred) ? 1 : 0;
      m_red  = res_taken ? 1 : 0;
      if (m_mis == 1) m_mcnt = (m_mcnt + 1) % (1 << CNT_W);
    end else begin
      m_mis = 0; m_red = 0;
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; pred_valid = v.pv; pred_pc = v.ppc; pred_op = v.pop;
    res_valid = v.rv; res_pc = v.rpc; res_op = v.rop; res_taken = v.rt; res_pred = v.rp;
  endtask

  function automatic vec_t mk(input logic r, input logic pv, input logic [31:0] ppc,
                              input logic [5:0] pop, input logic rv, input logic [31:0] rpc,
                              input logic [5:0] rop, input logic rt, input logic rp,
                              input logic ep, input logic em, input logic er,
                              input int eb, input int ec);
    vec_t v;
    v.rst = r; v.pv = pv; v.ppc = ppc; v.pop = pop; v.rv = rv; v.rpc = rpc;
    v.rop = rop; v.rt = rt; v.rp = rp; v.e_pred = ep; v.e_mis = em; v.e_red = er;
    v.e_bcnt = eb; v.e_mcnt = ec;
    return v;
  endfunction

  vec_t vecs [$];
  vec_t v;

  initial begin
    rst = 1'b1; pred_valid = 1'b0; pred_pc = '0; pred_op = '0;
    res_valid = 1'b0; res_pc = '0; res_op = '0; res_taken = 1'b0; res_pred = 1'b0;

    //            rst pv ppc     pop      rv rpc     rop      rt rp  pred mis red bcnt mcnt
    vecs.push_back(mk(1, 0, 32'h0,   OP_BEQ,  0, 32'h0,   OP_BEQ,  0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h40,  OP_BEQ,  0, 32'h0,   OP_BEQ,  0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h40,  OP_LW,   0, 32'h0,   OP_BEQ,  0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,   OP_BEQ,  1, 32'h40,  OP_BEQ,  1, 0,  0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 32'h40,  OP_BEQ,  0, 32'h0,   OP_BEQ,  0, 0,  1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,   OP_BEQ,  1, 32'h80,  OP_BNE,  1, 1,  0, 0, 1, 2, 1));
    vecs.push_back(mk(0, 0, 32'h0,   OP_BEQ,  1, 32'h80,  OP_BNE,  1, 1,  0, 0, 1, 3, 1));
    vecs.push_back(mk(0, 0, 32'h0,   OP_BEQ,  1, 32'h80,  OP_BNE,  1, 1,  0, 0, 1, 4, 1));
    vecs.push_back(mk(0, 0, 32'h0,   OP_BEQ,  1, 32'h80,  OP_BNE,  1, 1,  0, 0, 1, 5, 1));
    vecs.push_back(mk(0, 1, 32'h80,  OP_BNE,  1, 32'h80,  OP_BNE,  0, 1,  1, 1, 0, 6, 2));
    vecs.push_back(mk(0, 1, 32'h80,  OP_BNE,  0, 32'h0,   OP_BEQ,  0, 0,  1, 0, 0, 6, 2));
    vecs.push_back(mk(0, 1, 32'h80,  OP_BLE,  1, 32'h80,  OP_BLTZ, 0, 1,  0, 1, 0, 7, 3));
    vecs.push_back(mk(0, 1, 32'h80,  OP_BLE,  0, 32'h0,   OP_BEQ,  0, 0,  0, 0, 0, 7, 3));
    vecs.push_back(mk(0, 1, 32'h100, OP_BEQ,  1, 32'h100, OP_BEQ,  1, 0,  1, 1, 1, 8, 4));
    vecs.push_back(mk(0, 1, 32'h200, OP_BEQ,  0, 32'h0,   OP_BEQ,  0, 0,  1, 0, 0, 8, 4));
    vecs.push_back(mk(0, 1, 32'h200, OP_BEQ,  1, 32'h200, OP_ADDI, 0, 1,  1, 0, 0, 8, 4));
    vecs.push_back(mk(0, 1, 32'h200, OP_BEQ,  0, 32'h200, OP_BEQ,  0, 1,  1, 0, 0, 8, 4));
    vecs.push_back(mk(0, 1, 32'h200, OP_BEQ,  1, 32'h200, OP_BEQ,  0, 0,  0, 0, 0, 9, 4));
    vecs.push_back(mk(1, 0, 32'h40,  OP_BEQ,  1, 32'h40,  OP_BEQ,  0, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h40,  OP_BEQ,  0, 32'h0,   OP_BEQ,  0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 32'h80,  OP_BEQ,  0, 32'h0,   OP_BEQ,  0, 0,  0, 0, 0, 0, 0));

    // Directed vectors: prediction checked before the edge, registered
    // outputs checked just after it.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("vec%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_pred));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d mispredict", i), 32'(mispredict), 32'(vecs[i].e_mis));
      check($sformatf("vec%0d redirect", i), 32'(redirect_taken), 32'(vecs[i].e_red));
      check($sformatf("vec%0d branch_cnt", i), 32'(branch_cnt), 32'(vecs[i].e_bcnt));
      check($sformatf("vec%0d mispredict_cnt", i), 32'(mispredict_cnt), 32'(vecs[i].e_mcnt));
    end

    // Randomized traffic against the model, starting from a reset.
    for (int n = 0; n < 2000; n++) begin
      logic [5:0] ops [6];
      ops[0] = OP_BEQ; ops[1] = OP_BNE; ops[2] = OP_BLTZ;
      ops[3] = OP_BLE; ops[4] = OP_LW;  ops[5] = OP_ADDI;
      @(negedge clk);
      rst        = (n == 0) || ($urandom_range(0, 199) == 0);
      pred_valid = $urandom_range(0, 3) != 0;
      pred_pc    = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 1) * 256);
      pred_op    = ops[$urandom_range(0, 5)];
      res_valid  = $urandom_range(0, 3) != 0;
      res_pc     = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 1) * 256);
      res_op     = ops[$urandom_range(0, 5)];
      res_taken  = 1'($urandom_range(0, 1));
      res_pred   = 1'($urandom_range(0, 1));
      #1;
      check("rand pred_taken", 32'(pred_taken), 32'(m_predict()));
      m_edge();
      @(posedge clk);
      #1;
      check("rand mispredict", 32'(mispredict), 32'(m_mis));
      check("rand redirect", 32'(redirect_taken), 32'(m_red));
      check("rand branch_cnt", 32'(branch_cnt), 32'(m_bcnt));
      check("rand mispredict_cnt", 32'(mispredict_cnt), 32'(m_mcnt));
    end

    // Statistics wrap: 65535 correctly predicted resolves, then one more.
    @(negedge clk);
    drive(mk(1, 0, 32'h0, OP_BEQ, 0, 32'h0, OP_BEQ, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0; res_valid = 1'b1; res_op = OP_BNE; res_pc = 32'h44;
    for (int n = 0; n < 65535; n++) begin
      res_taken = 1'($urandom_range(0, 1));
      res_pred  = res_taken;
      @(negedge clk);
    end
    res_valid = 1'b0;
    #1;
    check("wrap preload branch_cnt", 32'(branch_cnt), 32'h0000_FFFF);
    check("wrap preload mispredict_cnt", 32'(mispredict_cnt), 32'h0);
    @(negedge clk);
    res_valid = 1'b1; res_taken = 1'b1; res_pred = 1'b0;
    @(posedge clk);
    #1;
    check("wrap branch_cnt", 32'(branch_cnt), 32'h0);
    check("wrap mispredict_cnt", 32'(mispredict_cnt), 32'h1);
    check("wrap mispredict", 32'(mispredict), 32'h1);
    @(negedge clk);
    res_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pulse ends", 32'(mispredict), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Fetch-side companion to the EX-stage branch decision unit.
- Holds a direct-mapped table of 2-bit saturating counters indexed by PC.
- Gives a taken/not-taken prediction to IF for conditional branches.
- Is trained by the resolved outcome from EX, and flags mispredictions so the pipeline can flush and redirect.

Parameters:
IDX_W, 6, table index width; table has 2^IDX_W entries
CNT_W, 16, width of the statistics counters

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
pred_valid_i  input  1  IF stage presents an instruction for prediction
pred_pc_i  input  32  PC of the fetched instruction
pred_op_i  input  6  opcode field (instr[31:26]) of the fetched instruction
pred_taken_o  output  1  combinational prediction for the current fetch
res_valid_i  input  1  EX stage resolves an instruction this cycle
res_pc_i  input  32  PC of the resolving instruction
res_op_i  input  6  opcode of the resolving instruction
res_taken_i  input  1  actual outcome from the branch decision unit
res_pred_i  input  1  prediction originally issued for this instruction, carried down the pipeline
mispredict_o  output  1  registered; resolved branch disagreed with its prediction
redirect_taken_o  output  1  registered; copy of res_taken_i for the mispredicted branch (1 = go to target, 0 = go to PC+4)
branch_cnt_o  output  CNT_W  number of resolved branches since reset
mispredict_cnt_o  output  CNT_W  number of mispredictions since reset

Behaviour:
- Branch opcodes: 000100 beq, 000101 bne/bnez, 000001 bltz, 000110 ble. Any other opcode is a non-branch.
- Index: pc[IDX_W+1:2]. No tags; aliasing is accepted.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Predict taken iff MSB = 1.
- Reset (rst_i = 1 at a clock edge):
  - every table entry goes to 01;
  - mispredict_o = 0, redirect_taken_o = 0;
  - both statistics counters = 0.
  - Reset dominates a simultaneous res_valid_i: no update occurs and any pending mispredict is dropped.
- Prediction (zero latency, combinational from table state):
  - pred_taken_o = MSB of the indexed entry when pred_valid_i = 1 and pred_op_i is a branch; otherwise 0.
  - Bypass: if a qualifying resolve in the same cycle hits the same index, pred_taken_o reflects the post-update counter value.
- Update (qualifying resolve = res_valid_i = 1 and res_op_i is a branch):
  - on the next edge the indexed counter increments if res_taken_i = 1, saturating at 11;
  - it decrements if res_taken_i = 0, saturating at 00.
  - Non-branch or invalid resolves leave the table untouched.
- Mispredict (1-cycle latency):
  - on the edge after a qualifying resolve, mispredict_o = (res_taken_i != res_pred_i) and redirect_taken_o = res_taken_i;
  - in every other cycle both are 0, so each is a single-cycle pulse per event;
  - back-to-back resolves produce independent pulses.
- Statistics:
  - branch_cnt_o increments by 1 for each qualifying resolve;
  - mispredict_cnt_o increments by 1 for each mispredicting resolve;
  - both wrap modulo 2^CNT_W;
  - both are updated on the same edge as the table.
- Predict and resolve at different indices in the same cycle are fully independent.

Test Plan:
- Reset, then predict at pc=0x0000_0040 op=000100 -> pred_taken_o=0 (entry 01); op=100011 -> pred_taken_o=0.
- Resolve pc=0x40 beq taken with res_pred_i=0 -> next cycle mispredict_o=1, redirect_taken_o=1, branch_cnt_o=1, mispredict_cnt_o=1; a following predict at 0x40 gives pred_taken_o=1 (entry 10).
- Four consecutive taken resolves at 0x80 -> entry saturates at 11; then one not-taken resolve -> entry 10, pred_taken_o still 1; a second not-taken -> entry 01, pred_taken_o=0.
- Same-cycle predict and taken resolve at 0x100 from entry 01 -> pred_taken_o=1 in that cycle (bypass). Aliasing: pc 0x100 and 0x200 (IDX_W=6) share entry 0, so training one changes the other's prediction.
- Resolve with res_op_i=001000 or res_valid_i=0 -> no table change, no mispredict_o pulse, counters unchanged.
- rst_i asserted in the same cycle as a mispredicting resolve -> mispredict_o stays 0, counters 0, all entries 01. Preload branch_cnt_o to 0xFFFF via 65535 resolves, then one more -> wraps to 0x0000.
